// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the PA-RISC pipeline hazard controller.
// State, forwarding-select and register constants.
package pa_risc_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run_en;
    logic [4:0]       id_ra;
    logic [4:0]       id_rb;
    logic             id_ra_used;
    logic             id_rb_used;
    logic [4:0]       ex_rd;
    logic             ex_rf_le;
    logic             ex_load;
    logic             ex_branch_taken;
    logic             ex_nullify;
    logic [4:0]       mem_rd;
    logic             mem_rf_le;
    logic [4:0]       wb_rd;
    logic             wb_rf_le;
    logic             pc_le;
    logic             ifid_le;
    logic             ifid_clr;
    logic             idex_clr;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output run_en, id_ra, id_rb, id_ra_used, id_rb_used,
        output ex_rd, ex_rf_le, ex_load, ex_branch_taken, ex_nullify,
        output mem_rd, mem_rf_le, wb_rd, wb_rf_le,
        input  pc_le, ifid_le, ifid_clr, idex_clr,
        input  fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  run_en, id_ra, id_rb, id_ra_used, id_rb_used,
        input  ex_rd, ex_rf_le, ex_load, ex_branch_taken, ex_nullify,
        input  mem_rd, mem_rf_le, wb_rd, wb_rf_le,
        output pc_le, ifid_le, ifid_clr, idex_clr,
        output fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select; nearest producing stage wins.
// r0 is hardwired, so it is never forwarded.
module fwd_sel
    import pa_risc_pkg::*;
(
    input  logic [4:0] src,
    input  logic       used,
    input  logic [4:0] ex_rd,
    input  logic       ex_rf_le,
    input  logic [4:0] mem_rd,
    input  logic       mem_rf_le,
    input  logic [4:0] wb_rd,
    input  logic       wb_rf_le,
    output fwd_t       sel
);

    always_comb begin
        sel = FWD_RF;
        if (used && src != REG_ZERO) begin
            if (ex_rf_le && ex_rd == src)
                sel = FWD_EX;
            else if (mem_rf_le && mem_rd == src)
                sel = FWD_MEM;
            else if (wb_rf_le && wb_rd == src)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch flushes,
// operand forwarding and saturating debug event counters.
module pipe_hazard_ctrl
    import pa_risc_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_hazard_ctrl_if.slave    bus
);

    logic [1:0]       st_q, st_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_inc;
    logic             flush_inc;
    logic             lu_haz;
    fwd_t             sel_a, sel_b;

    assign lu_haz = bus.ex_load && bus.ex_rf_le &&
                    bus.ex_rd != REG_ZERO &&
                    ((bus.id_ra_used && bus.id_ra == bus.ex_rd) ||
                     (bus.id_rb_used && bus.id_rb == bus.ex_rd));

    always_comb begin
        bus.pc_le    = 1'b0;
        bus.ifid_le  = 1'b0;
        bus.ifid_clr = 1'b0;
        bus.idex_clr = 1'b0;
        st_d         = st_q;
        rem_d        = rem_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!reset) begin
            bus.ifid_clr = 1'b1;
            bus.idex_clr = 1'b1;
        end else begin
            unique case (st_q)
                ST_RUN: begin
                    if (!bus.run_en) begin
                        st_d = ST_HALT;
                    end else if (bus.ex_branch_taken) begin
                        // delay slot in ID survives unless nullified
                        bus.pc_le    = 1'b1;
                        bus.ifid_le  = 1'b1;
                        bus.ifid_clr = 1'b1;
                        bus.idex_clr = bus.ex_nullify;
                        flush_inc    = 1'b1;
                    end else if (lu_haz) begin
                        bus.idex_clr = 1'b1;
                        stall_inc    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            rem_d = 3'(LOAD_STALL_CYCLES - 1);
                            st_d  = ST_STALL;
                        end
                    end else begin
                        bus.pc_le   = 1'b1;
                        bus.ifid_le = 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!bus.run_en) begin
                        st_d = ST_HALT;
                    end else begin
                        bus.idex_clr = 1'b1;
                        stall_inc    = 1'b1;
                        rem_d        = (rem_q == 3'd0) ? 3'd0 : rem_q - 3'd1;
                        if (rem_q <= 3'd1)
                            st_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (bus.run_en)
                        st_d = (rem_q != 3'd0) ? ST_STALL : ST_RUN;
                end
                default: st_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q    <= ST_RUN;
            rem_q   <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            st_q  <= st_d;
            rem_q <= rem_d;
            if (stall_inc && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (flush_inc && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    fwd_sel u_fwd_a (
        .src       (bus.id_ra),
        .used      (bus.id_ra_used),
        .ex_rd     (bus.ex_rd),
        .ex_rf_le  (bus.ex_rf_le),
        .mem_rd    (bus.mem_rd),
        .mem_rf_le (bus.mem_rf_le),
        .wb_rd     (bus.wb_rd),
        .wb_rf_le  (bus.wb_rf_le),
        .sel       (sel_a)
    );

    fwd_sel u_fwd_b (
        .src       (bus.id_rb),
        .used      (bus.id_rb_used),
        .ex_rd     (bus.ex_rd),
        .ex_rf_le  (bus.ex_rf_le),
        .mem_rd    (bus.mem_rd),
        .mem_rf_le (bus.mem_rf_le),
        .wb_rd     (bus.wb_rd),
        .wb_rf_le  (bus.wb_rf_le),
        .sel       (sel_b)
    );

    assign bus.fwd_a     = reset ? sel_a : FWD_RF;
    assign bus.fwd_b     = reset ? sel_b : FWD_RF;
    assign bus.state     = st_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controller configurations driven in lockstep.
// u1: 1 bubble, u3: 3 bubbles, us: 1 bubble with 4-bit counters.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       run_en;
    logic [4:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
    logic       id_ra_used, id_rb_used;
    logic       ex_rf_le, ex_load, ex_branch_taken, ex_nullify;
    logic       mem_rf_le, wb_rf_le;

    pipe_hazard_ctrl_if #(.CNT_W(16)) i1 ();
    pipe_hazard_ctrl_if #(.CNT_W(16)) i3 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  is ();

    assign i1.run_en = run_en;          assign i3.run_en = run_en;
    assign is.run_en = run_en;
    assign i1.id_ra = id_ra;            assign i3.id_ra = id_ra;
    assign is.id_ra = id_ra;
    assign i1.id_rb = id_rb;            assign i3.id_rb = id_rb;
    assign is.id_rb = id_rb;
    assign i1.id_ra_used = id_ra_used;  assign i3.id_ra_used = id_ra_used;
    assign is.id_ra_used = id_ra_used;
    assign i1.id_rb_used = id_rb_used;  assign i3.id_rb_used = id_rb_used;
    assign is.id_rb_used = id_rb_used;
    assign i1.ex_rd = ex_rd;            assign i3.ex_rd = ex_rd;
    assign is.ex_rd = ex_rd;
    assign i1.ex_rf_le = ex_rf_le;      assign i3.ex_rf_le = ex_rf_le;
    assign is.ex_rf_le = ex_rf_le;
    assign i1.ex_load = ex_load;        assign i3.ex_load = ex_load;
    assign is.ex_load = ex_load;
    assign i1.ex_branch_taken = ex_branch_taken;
    assign i3.ex_branch_taken = ex_branch_taken;
    assign is.ex_branch_taken = ex_branch_taken;
    assign i1.ex_nullify = ex_nullify;  assign i3.ex_nullify = ex_nullify;
    assign is.ex_nullify = ex_nullify;
    assign i1.mem_rd = mem_rd;          assign i3.mem_rd = mem_rd;
    assign is.mem_rd = mem_rd;
    assign i1.mem_rf_le = mem_rf_le;    assign i3.mem_rf_le = mem_rf_le;
    assign is.mem_rf_le = mem_rf_le;
    assign i1.wb_rd = wb_rd;            assign i3.wb_rd = wb_rd;
    assign is.wb_rd = wb_rd;
    assign i1.wb_rf_le = wb_rf_le;      assign i3.wb_rf_le = wb_rf_le;
    assign is.wb_rf_le = wb_rf_le;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .bus(i1.slave));
    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
        .clk(clk), .reset(reset), .bus(i3.slave));
    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) us (
        .clk(clk), .reset(reset), .bus(is.slave));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        run_en = 1'b1;
        id_ra = 5'd0; id_rb = 5'd0; ex_rd = 5'd0;
        mem_rd = 5'd0; wb_rd = 5'd0;
        id_ra_used = 1'b0; id_rb_used = 1'b0;
        ex_rf_le = 1'b0; ex_load = 1'b0;
        ex_branch_taken = 1'b0; ex_nullify = 1'b0;
        mem_rf_le = 1'b0; wb_rf_le = 1'b0;
    endtask

    task automatic hazard();
        ex_load = 1'b1; ex_rf_le = 1'b1; ex_rd = 5'd5;
        id_ra = 5'd5; id_ra_used = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        ex_rd = 5'd5; ex_rf_le = 1'b1; id_ra = 5'd5; id_ra_used = 1'b1;
        tick();
        tick();
        check("rst_pc_le", int'(i1.pc_le), 0);
        check("rst_ifid_le", int'(i1.ifid_le), 0);
        check("rst_ifid_clr", int'(i1.ifid_clr), 1);
        check("rst_idex_clr", int'(i1.idex_clr), 1);
        check("rst_fwd_a", int'(i1.fwd_a), 0);
        check("rst_stall", int'(i1.stall_cnt), 0);
        check("rst_flush", int'(i1.flush_cnt), 0);
        check("rst_state", int'(i3.state), 0);

        // single and multi-cycle load-use stall
        reset = 1'b1;
        idle();
        hazard();
        #1;
        check("lu_pc_le", int'(i1.pc_le), 0);
        check("lu_ifid_le", int'(i1.ifid_le), 0);
        check("lu_idex_clr", int'(i1.idex_clr), 1);
        check("lu_ifid_clr", int'(i1.ifid_clr), 0);
        check("lu_fwd_a", int'(i1.fwd_a), 1);
        check("lu3_idex_clr", int'(i3.idex_clr), 1);
        tick();
        idle();
        #1;
        check("lu1_stall", int'(i1.stall_cnt), 1);
        check("lu1_state", int'(i1.state), 0);
        check("lu1_pc_le", int'(i1.pc_le), 1);
        check("lu3_state1", int'(i3.state), 1);
        check("lu3_bub2", int'(i3.idex_clr), 1);
        check("lu3_pc2", int'(i3.pc_le), 0);
        tick();
        check("lu3_bub3", int'(i3.idex_clr), 1);
        check("lu3_stall2", int'(i3.stall_cnt), 2);
        tick();
        check("lu3_state_run", int'(i3.state), 0);
        check("lu3_stall3", int'(i3.stall_cnt), 3);
        check("lu3_no_bub", int'(i3.idex_clr), 0);
        check("lu3_pc_le", int'(i3.pc_le), 1);

        // halt in the middle of a 3-cycle stall
        do_reset();
        hazard();
        tick();
        idle();
        run_en = 1'b0;
        #1;
        check("h_freeze_clr", int'(i3.idex_clr), 0);
        check("h_freeze_pc", int'(i3.pc_le), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("h_state", int'(i3.state), 2);
            check("h_idex_clr", int'(i3.idex_clr), 0);
            check("h_ifid_clr", int'(i3.ifid_clr), 0);
            check("h_stall", int'(i3.stall_cnt), 1);
        end
        run_en = 1'b1;
        #1;
        check("h_resume_state", int'(i3.state), 2);
        check("h_resume_clr", int'(i3.idex_clr), 0);
        check("h_resume_pc", int'(i3.pc_le), 0);
        tick();
        check("h_bub2", int'(i3.idex_clr), 1);
        check("h_bub2_st", int'(i3.state), 1);
        tick();
        check("h_bub3", int'(i3.idex_clr), 1);
        tick();
        check("h_end_state", int'(i3.state), 0);
        check("h_end_stall", int'(i3.stall_cnt), 3);
        check("h_end_pc", int'(i3.pc_le), 1);

        // taken branches, with and without nullify, and over a load-use
        do_reset();
        ex_branch_taken = 1'b1;
        #1;
        check("br_ifid_clr", int'(i1.ifid_clr), 1);
        check("br_idex_clr", int'(i1.idex_clr), 0);
        check("br_pc_le", int'(i1.pc_le), 1);
        check("br_ifid_le", int'(i1.ifid_le), 1);
        tick();
        check("br_flush1", int'(i1.flush_cnt), 1);
        ex_nullify = 1'b1;
        #1;
        check("brn_idex_clr", int'(i1.idex_clr), 1);
        check("brn_ifid_clr", int'(i1.ifid_clr), 1);
        tick();
        check("brn_flush2", int'(i1.flush_cnt), 2);
        ex_nullify = 1'b0;
        hazard();
        #1;
        check("brlu_pc_le", int'(i3.pc_le), 1);
        check("brlu_idex_clr", int'(i3.idex_clr), 0);
        check("brlu_ifid_clr", int'(i3.ifid_clr), 1);
        tick();
        idle();
        #1;
        check("brlu_stall", int'(i3.stall_cnt), 0);
        check("brlu_flush", int'(i3.flush_cnt), 3);
        check("brlu_state", int'(i3.state), 0);

        // forwarding priority and exclusions
        idle();
        ex_rd = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
        ex_rf_le = 1'b1; mem_rf_le = 1'b1; wb_rf_le = 1'b1;
        id_rb = 5'd7; id_rb_used = 1'b1;
        #1;
        check("fwd_ex", int'(i1.fwd_b), 1);
        check("fwd_a_unused", int'(i1.fwd_a), 0);
        ex_rf_le = 1'b0;
        #1;
        check("fwd_mem", int'(i1.fwd_b), 2);
        mem_rf_le = 1'b0;
        #1;
        check("fwd_wb", int'(i1.fwd_b), 3);
        wb_rf_le = 1'b0;
        #1;
        check("fwd_none", int'(i1.fwd_b), 0);
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; id_rb = 5'd0;
        ex_rf_le = 1'b1; mem_rf_le = 1'b1; wb_rf_le = 1'b1;
        #1;
        check("fwd_r0", int'(i1.fwd_b), 0);
        ex_rd = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; id_rb = 5'd7;
        id_rb_used = 1'b0;
        #1;
        check("fwd_unused", int'(i1.fwd_b), 0);

        // counter saturation on the 4-bit instance
        do_reset();
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14)
                check("sat_reach", int'(is.flush_cnt), 15);
        end
        check("sat_flush", int'(is.flush_cnt), 15);
        check("sat_wide", int'(i1.flush_cnt), 20);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage PA-RISC pipeline (IF, ID, EX, MEM, WB).
- Gates the PC and IF/ID load enables.
- Clears IF/ID and injects ID/EX bubbles for load-use stalls and taken branches or BL, honouring the delay slot and the nullify bit.
- Produces operand forwarding selects and keeps saturating stall/flush event counters for debug.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of the stall_cnt and flush_cnt counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk).
- run_en  in  1  global pipeline enable (the LE from top level); 0 freezes the pipeline.
- id_ra  in  5  ID-stage source register A.
- id_rb  in  5  ID-stage source register B.
- id_ra_used  in  1  ID instruction reads ra.
- id_rb_used  in  1  ID instruction reads rb.
- ex_rd  in  5  EX destination register.
- ex_rf_le  in  1  EX instruction writes the register file.
- ex_load  in  1  EX instruction is LDW/LDH/LDB (EX_L).
- ex_branch_taken  in  1  branch/BL resolved taken in EX (COMBT, COMBF, BL).
- ex_nullify  in  1  taken branch nullifies its delay slot.
- mem_rd  in  5  MEM destination register.
- mem_rf_le  in  1  MEM writes the register file.
- wb_rd  in  5  WB destination register.
- wb_rf_le  in  1  WB writes the register file.
- pc_le  out  1  PC load enable.
- ifid_le  out  1  IF/ID register load enable.
- ifid_clr  out  1  IF/ID loads a NOP.
- idex_clr  out  1  ID/EX loads a NOP (CU mux select).
- fwd_a  out  2  operand A select.
- fwd_b  out  2  operand B select.
- state  out  2  FSM state, for debug.
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=RUN, remaining count rem=0, stall_cnt=0, flush_cnt=0.
  - While reset==0 the combinational outputs are forced to pc_le=0, ifid_le=0, ifid_clr=1, idex_clr=1, fwd_a=fwd_b=00.
  - Reset mid-stall abandons the stall.
- FSM states: RUN=00, STALL=01, HALT=10. 11 is illegal and goes to RUN.
- Hazard detection (combinational):
  - lu_haz = ex_load & ex_rf_le & ex_rd!=0 & ((id_ra_used & id_ra==ex_rd) | (id_rb_used & id_rb==ex_rd)).
- RUN, evaluated in priority order:
  1. run_en=0: pc_le=ifid_le=0, no clears, next state HALT, rem held.
  2. ex_branch_taken=1 (branch wins if ex_load is also asserted; lu_haz suppressed):
     - pc_le=1, ifid_le=1, ifid_clr=1 (kills the wrong-path fetch).
     - idex_clr=ex_nullify (the delay slot in ID proceeds unless nullified).
     - flush_cnt+1. Next state RUN.
  3. lu_haz=1:
     - pc_le=0, ifid_le=0, idex_clr=1, stall_cnt+1.
     - If LOAD_STALL_CYCLES>1: rem=LOAD_STALL_CYCLES-1, next state STALL. Otherwise stay in RUN.
  4. Otherwise: pc_le=ifid_le=1, no clears.
- STALL:
  - run_en=0: freeze, next state HALT, rem preserved.
  - Otherwise: pc_le=ifid_le=0, idex_clr=1, stall_cnt+1, rem-1. When rem reaches 0, next state RUN.
  - Hazard inputs are ignored in STALL.
- HALT:
  - pc_le=ifid_le=0, no clears, counters frozen.
  - On run_en=1: next state STALL if rem!=0, else RUN. The resume cycle itself is still a HALT-output cycle.
- Forwarding (combinational, per operand):
  - 01 = EX if ex_rf_le & ex_rd==src & src!=0.
  - Else 10 = MEM if mem_rf_le & mem_rd==src & src!=0.
  - Else 11 = WB on the equivalent WB match.
  - Else 00 = register file.
  - Select is 00 when the operand is unused.
  - EX forwarding of a load is harmless because the same cycle inserts a bubble.
- Counters saturate at all-ones and never wrap.
- All registered updates occur on the rising edge of clk; outputs are valid in the same cycle as the inputs.

Decomposition:
- pa_risc_pkg holds:
  - state encodings ST_RUN, ST_STALL, ST_HALT;
  - forwarding selects FWD_RF, FWD_EX, FWD_MEM, FWD_WB;
  - REG_ZERO=5'd0.
- One sub-module, fwd_sel, holds the per-operand priority forwarding logic and is instantiated twice (operands A and B).

Test Plan:
- Reset and load-use hazard: hold reset=0 for 2 cycles, release, then apply ex_load=1, ex_rf_le=1, ex_rd=5, id_ra=5, id_ra_used=1 for one cycle.
  - During reset: pc_le=0, ifid_clr=1, idex_clr=1, counters 0.
  - Hazard cycle: pc_le=0, ifid_le=0, idex_clr=1. Next cycle stall_cnt=1 and state RUN (LOAD_STALL_CYCLES=1).
- Multi-cycle stall: set LOAD_STALL_CYCLES=3 and apply the same hazard -> exactly 3 consecutive bubble cycles, stall_cnt=3, then RUN.
- Halt mid-stall: with LOAD_STALL_CYCLES=3, drop run_en after the first bubble for 4 cycles, then restore it.
  - state=HALT with no clears and stall_cnt frozen at 1.
  - After resume: one HALT-output cycle, then 2 more bubbles, final stall_cnt=3.
- Taken branch:
  - ex_branch_taken=1, ex_nullify=0 -> ifid_clr=1, idex_clr=0, pc_le=1, flush_cnt=1.
  - Repeat with ex_nullify=1 -> idex_clr=1, flush_cnt=2.
  - Branch with ex_load=1 and a matching lu_haz -> branch response only, stall_cnt unchanged.
- Forwarding priority: ex_rd=mem_rd=wb_rd=7, all rf_le=1, id_rb=7, id_rb_used=1.
  - fwd_b=01; clear ex_rf_le -> 10; clear mem_rf_le -> 11.
  - id_rb=0 -> 00.
  - id_rb_used=0 -> 00.
- Saturation (CNT_W=4): apply 20 consecutive taken branches -> flush_cnt stops at 15.
